// File: rtl/custom_bus_if.sv
// Signal bundle between custom_bus_master and its surroundings.
// The master modport is the bus master itself. The slave modport is everything
// on the far side: the command issuer / response consumer and the bus slave.
interface custom_bus_if;
  // Command port (valid/ready).
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_r0_w1;
  logic [7:0] cmd_wdata;

  // Response port (valid/ready).
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  // req/ack bus toward custom_bus_slave.
  logic       m_req;
  logic       m_r0_w1;
  logic [7:0] m_wr_data;
  logic       m_done;
  logic       s_ack;
  logic       s_data_ack;
  logic [7:0] m_rd_data;

  modport master (
    input  cmd_valid, cmd_r0_w1, cmd_wdata,
    input  rsp_ready,
    input  s_ack, s_data_ack, m_rd_data,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output m_req, m_r0_w1, m_wr_data, m_done
  );

  modport slave (
    output cmd_valid, cmd_r0_w1, cmd_wdata,
    output rsp_ready,
    output s_ack, s_data_ack, m_rd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  m_req, m_r0_w1, m_wr_data, m_done
  );
endinterface

// File: rtl/custom_bus_master.sv
// Bus master for the custom 8-bit req/ack bus.
// Takes one read/write command, runs m_req -> s_ack -> (write: data ->
// s_data_ack) -> m_done on the bus, then presents read data or a timeout
// error on the response port. Every output is decoded from registered state,
// so there is no combinational path from any input to any output.
module custom_bus_master #(
  parameter int TIMEOUT = 16  // cycles to wait for an ack before aborting; 0 = wait forever
) (
  input logic          clk,
  input logic          rst,
  custom_bus_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WR_DATA,
    WAIT_DACK,
    DONE,
    RESP
  } state_t;

  // The counter only ever reaches TIMEOUT-1; keep at least one bit so the
  // TIMEOUT=0 build still has a legal vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_ON = (TIMEOUT > 0);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;      // captured direction, 1 = write
  logic [7:0]       wdata_q, wdata_d;  // captured write data
  logic [7:0]       rdata_q, rdata_d;  // read data sampled on s_ack
  logic             err_q, err_d;      // set when a wait phase timed out
  logic [CNT_W-1:0] cnt_q, cnt_d;      // cycles spent in the current wait phase

  logic             limit_hit;

  // Last permitted cycle of a wait phase without the awaited ack.
  assign limit_hit = TIMEOUT_ON && (cnt_q == CNT_LIMIT);

  // State and captured-transaction registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and capture logic for the transaction sequence.
  // NOTE: every variable gets a default at the top so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          dir_d   = bus.cmd_r0_w1;
          wdata_d = bus.cmd_wdata;
          rdata_d = 8'h00;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        // An ack in the limit cycle is checked first, so it beats the timeout.
        if (bus.s_ack) begin
          if (dir_q) begin
            state_d = WR_DATA;
          end else begin
            rdata_d = bus.m_rd_data;
            state_d = DONE;
          end
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT_ON) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_DATA: begin
        // The slave samples m_wr_data during this single cycle.
        cnt_d   = '0;
        state_d = WAIT_DACK;
      end

      WAIT_DACK: begin
        if (bus.s_data_ack) begin
          state_d = DONE;
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT_ON) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // m_done pulses even after a timeout so a stuck slave is released.
        state_d = RESP;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state and captured data only.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 8'h00;
    bus.rsp_err   = 1'b0;
    bus.m_req     = 1'b0;
    bus.m_r0_w1   = 1'b0;
    bus.m_wr_data = 8'h00;
    bus.m_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
      end

      REQ, WR_DATA, WAIT_DACK, DONE: begin
        bus.m_req     = (state_q == REQ);
        bus.m_done    = (state_q == DONE);
        bus.m_r0_w1   = dir_q;
        bus.m_wr_data = dir_q ? wdata_q : 8'h00;
      end

      RESP: begin
        // rdata_q stays 0 for writes and timeouts: it is cleared on accept
        // and only loaded by a read that received s_ack.
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end

      default: begin
        bus.cmd_ready = 1'b0;
      end
    endcase
  end

endmodule
